alu_arbiter: RTL and testbench

- Shares one combinational ALU between two requesters: requester 0 is the main execute path and requester 1 is the auxiliary address/branch path.
- Round-robin arbitration with a valid/ready handshake on requests and a registered, per-requester response buffer with backpressure.
- The result and zero flag are returned one cycle after acceptance.
- Sits between the control/decode logic and the team's existing `alu` module (a, b, 2-bit sel, out, zeroFlag).

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu.sv | 34 +++
 rtl/alu_rsp_buf.sv | 52 +++++
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared ALU op encodings and default datapath width.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module : alu
// Brief  : Combinational add/sub/and/or unit with zero flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic             zeroFlag
);

    always_comb begin
        out = '0;
        case (sel)
            ALU_ADD: out = a + b;
            ALU_SUB: out = a - b;
            ALU_AND: out = a & b;
            ALU_OR:  out = a | b;
        endcase
    end

    assign zeroFlag = (out == '0);

endmodule : alu

`default_nettype wire

// File: rtl/alu_rsp_buf.sv
// ============================================================================
// Module : alu_rsp_buf
// Brief  : One-entry valid/ready response register with load and drain.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_rsp_buf
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_out,
    input  logic             i_zero,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_out,
    output logic             o_zero,
    output logic             o_elig
);

    logic             r_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_zero;

    // A load wins over a drain so that a consumed entry can be refilled in
    // the same cycle; the data fields are only written on a load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_out   <= '0;
            r_zero  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_out   <= i_out;
            r_zero  <= i_zero;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_out   = r_out;
    assign o_zero  = r_zero;
    assign o_elig  = !r_valid || i_ready;

endmodule : alu_rsp_buf

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module : alu_arbiter
// Brief  : Round-robin share of one ALU between two requesters with
//          registered, backpressured per-requester responses.
//          Optional statistics counters: define ALU_ARB_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_sel,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_out,
    output logic             rsp0_zero,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_sel,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_out,
    output logic             rsp1_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [31:0]      grant_cnt0,
    output logic [31:0]      grant_cnt1,
    output logic [31:0]      conflict_cnt
`endif
);

    logic             r_rr_last;
    logic             w_elig0;
    logic             w_elig1;
    logic             w_cand0;
    logic             w_cand1;
    logic             w_grant0;
    logic             w_grant1;
    logic [WIDTH-1:0] w_alu_a;
    logic [WIDTH-1:0] w_alu_b;
    logic [1:0]       w_alu_sel;
    logic [WIDTH-1:0] w_alu_out;
    logic             w_alu_zero;

    assign w_cand0 = req0_valid && w_elig0;
    assign w_cand1 = req1_valid && w_elig1;

    // On contention the requester that did not win last time goes first.
    assign w_grant0 = w_cand0 && (!w_cand1 || r_rr_last);
    assign w_grant1 = w_cand1 && (!w_cand0 || !r_rr_last);

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    // Idle cycles route requester 0 through the ALU; the result is dropped.
    assign w_alu_a   = w_grant1 ? req1_a   : req0_a;
    assign w_alu_b   = w_grant1 ? req1_b   : req0_b;
    assign w_alu_sel = w_grant1 ? req1_sel : req0_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_last <= 1'b1;
        end else if (w_grant0) begin
            r_rr_last <= 1'b0;
        end else if (w_grant1) begin
            r_rr_last <= 1'b1;
        end
    end

    alu #(
        .WIDTH    (WIDTH)
    ) u_alu (
        .a        (w_alu_a),
        .b        (w_alu_b),
        .sel      (w_alu_sel),
        .out      (w_alu_out),
        .zeroFlag (w_alu_zero)
    );

    alu_rsp_buf #(
        .WIDTH   (WIDTH)
    ) u_rsp_buf0 (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_grant0),
        .i_out   (w_alu_out),
        .i_zero  (w_alu_zero),
        .i_ready (rsp0_ready),
        .o_valid (rsp0_valid),
        .o_out   (rsp0_out),
        .o_zero  (rsp0_zero),
        .o_elig  (w_elig0)
    );

    alu_rsp_buf #(
        .WIDTH   (WIDTH)
    ) u_rsp_buf1 (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_grant1),
        .i_out   (w_alu_out),
        .i_zero  (w_alu_zero),
        .i_ready (rsp1_ready),
        .o_valid (rsp1_valid),
        .o_out   (rsp1_out),
        .o_zero  (rsp1_zero),
        .o_elig  (w_elig1)
    );

`ifdef ALU_ARB_STATS_EN
    logic [31:0] r_grant_cnt0;
    logic [31:0] r_grant_cnt1;
    logic [31:0] r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_cnt0   <= '0;
            r_grant_cnt1   <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_grant0) begin
                r_grant_cnt0 <= r_grant_cnt0 + 32'd1;
            end
            if (w_grant1) begin
                r_grant_cnt1 <= r_grant_cnt1 + 32'd1;
            end
            if (w_cand0 && w_cand1) begin
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            end
        end
    end

    assign grant_cnt0   = r_grant_cnt0;
    assign grant_cnt1   = r_grant_cnt1;
    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule : alu_arbiter

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module : tb_alu_arbiter
// Brief  : Directed scoreboard bench for alu_arbiter (honours ALU_ARB_STATS_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
    logic             req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
    logic [WIDTH-1:0] req0_a, req0_b, rsp0_out, req1_a, req1_b, rsp1_out;
    logic [1:0]       req0_sel, req1_sel;
`ifdef ALU_ARB_STATS_EN
    logic [31:0]      grant_cnt0, grant_cnt1, conflict_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [WIDTH:0] q0[$];
    logic [WIDTH:0] q1[$];

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_sel     (req0_sel),
        .rsp0_valid   (rsp0_valid),
        .rsp0_ready   (rsp0_ready),
        .rsp0_out     (rsp0_out),
        .rsp0_zero    (rsp0_zero),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_sel     (req1_sel),
        .rsp1_valid   (rsp1_valid),
        .rsp1_ready   (rsp1_ready),
        .rsp1_out     (rsp1_out),
        .rsp1_zero    (rsp1_zero)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt0   (grant_cnt0),
        .grant_cnt1   (grant_cnt1),
        .conflict_cnt (conflict_cnt)
`endif
    );

    // Reference model: {zero, out}
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, b, input logic [1:0] sel);
        logic [WIDTH-1:0] r;
        case (sel)
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = a & b;
            default: r = a | b;
        endcase
        return {(r == '0), r};
    endfunction

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set0(input logic v, input logic [WIDTH-1:0] a, b, input logic [1:0] sel);
        req0_valid = v; req0_a = a; req0_b = b; req0_sel = sel;
    endtask

    task automatic set1(input logic v, input logic [WIDTH-1:0] a, b, input logic [1:0] sel);
        req1_valid = v; req1_a = a; req1_b = b; req1_sel = sel;
    endtask

    // One clock: check grants/valids mid-cycle, score responses, log accepts.
    task automatic tick(input logic e_r0, e_r1, e_v0, e_v1);
        logic [WIDTH:0] e;
        @(negedge clk);
        chk("req0_ready", req0_ready, e_r0);
        chk("req1_ready", req1_ready, e_r1);
        chk("rsp0_valid", rsp0_valid, e_v0);
        chk("rsp1_valid", rsp1_valid, e_v1);
        if (rsp0_valid && rsp0_ready) begin
            chk("rsp0_has_expected", q0.size() != 0, 1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("rsp0_out", rsp0_out, e[WIDTH-1:0]);
                chk("rsp0_zero", rsp0_zero, e[WIDTH]);
            end
        end
        if (rsp1_valid && rsp1_ready) begin
            chk("rsp1_has_expected", q1.size() != 0, 1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("rsp1_out", rsp1_out, e[WIDTH-1:0]);
                chk("rsp1_zero", rsp1_zero, e[WIDTH]);
            end
        end
        if (req0_valid && req0_ready) q0.push_back(model(req0_a, req0_b, req0_sel));
        if (req1_valid && req1_ready) q1.push_back(model(req1_a, req1_b, req1_sel));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set0(0, 0, 0, 2'b00);
        set1(0, 0, 0, 2'b00);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        set0(0, 0, 0, 2'b00);
        set1(0, 0, 0, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_rsp0_valid", rsp0_valid, 0);
        chk("reset_rsp0_out", rsp0_out, 0);
        chk("reset_rsp0_zero", rsp0_zero, 0);
        chk("reset_rsp1_valid", rsp1_valid, 0);
        chk("reset_rsp1_out", rsp1_out, 0);
        chk("reset_rsp1_zero", rsp1_zero, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Lone request on requester 0: 5-3
        set0(1, 5, 3, 2'b01);
        tick(1, 0, 0, 0);
        set0(0, 0, 0, 2'b00);
        tick(0, 0, 1, 0);
        tick(0, 0, 0, 0);

        // Contention straight after reset: requester 0 first
        do_reset();
        set0(1, 7, 7, 2'b10);
        set1(1, 4, 1, 2'b11);
        tick(1, 0, 0, 0);
        set0(0, 0, 0, 2'b00);
        tick(0, 1, 1, 0);
        set1(0, 0, 0, 2'b00);
        tick(0, 0, 0, 1);

        // Backpressure on requester 0 while requester 1 keeps streaming
        rsp0_ready = 1'b0;
        set0(1, 10, 20, 2'b00);
        tick(1, 0, 0, 0);
        set0(1, 1, 1, 2'b00);
        set1(1, 2, 3, 2'b00);
        tick(0, 1, 1, 0);
        chk("bp_hold_out_a", rsp0_out, 30);
        set1(1, 3, 3, 2'b00);
        tick(0, 1, 1, 1);
        chk("bp_hold_out_b", rsp0_out, 30);
        rsp0_ready = 1'b1;
        set1(1, 4, 4, 2'b00);
        tick(1, 0, 1, 1);
        set0(0, 0, 0, 2'b00);
        tick(0, 1, 1, 0);
        set1(0, 0, 0, 2'b00);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);

        // Zero flag and wrap-around, issued back to back
        set0(1, 0, 1, 2'b01);
        tick(1, 0, 0, 0);
        set0(1, 9, 9, 2'b01);
        tick(1, 0, 1, 0);
        set0(1, 32'hFFFF_FFFF, 1, 2'b00);
        tick(1, 0, 1, 0);
        set0(0, 0, 0, 2'b00);
        tick(0, 0, 1, 0);
        tick(0, 0, 0, 0);

        // Streaming: eight back-to-back adds i+i
        for (int i = 0; i < 8; i++) begin
            set0(1, i, i, 2'b00);
            tick(1, 0, (i != 0), 0);
        end
        set0(0, 0, 0, 2'b00);
        tick(0, 0, 1, 0);
        tick(0, 0, 0, 0);

        // Reset right after a requester-1 accept; a reset-cycle accept is dropped
        set1(1, 6, 0, 2'b11);
        tick(0, 1, 0, 0);
        rst = 1'b1;
        set1(1, 0, 0, 2'b10);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set1(0, 0, 0, 2'b00);
        q1.delete();
        @(negedge clk);
        chk("midrst_rsp1_valid", rsp1_valid, 0);
        chk("midrst_rsp1_out", rsp1_out, 0);
        chk("midrst_rsp1_zero", rsp1_zero, 0);
`ifdef ALU_ARB_STATS_EN
        chk("midrst_grant_cnt0", grant_cnt0, 0);
        chk("midrst_grant_cnt1", grant_cnt1, 0);
        chk("midrst_conflict_cnt", conflict_cnt, 0);
`endif
        @(posedge clk);
        #1;
        set0(1, 1, 2, 2'b00);
        set1(1, 8, 8, 2'b01);
        tick(1, 0, 0, 0);
        set0(0, 0, 0, 2'b00);
        tick(0, 1, 1, 0);
        set1(0, 0, 0, 2'b00);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
`ifdef ALU_ARB_STATS_EN
        chk("stats_grant_cnt0", grant_cnt0, 1);
        chk("stats_grant_cnt1", grant_cnt1, 1);
        chk("stats_conflict_cnt", conflict_cnt, 1);
`endif

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_arbiter

`default_nettype wire
